// File: rtl/mem_access_unit_pkg.sv
// mem_pkg: shared types and constants for the MEM-stage data-memory access unit.
//   - state_t         : access FSM states (IDLE, WAIT)
//   - MTR_*           : MemtoReg write-back source encodings
//   - TIMEOUT_DEFAULT : default ack wait limit in cycles
//   - LANE_B*         : byte-lane selects on address bits [1:0]
//   - sext8()         : sign-extend a byte to 32 bits
package mem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [1:0] MTR_ALU = 2'b00;
  localparam logic [1:0] MTR_MEM = 2'b01;
  localparam logic [1:0] MTR_PC8 = 2'b10;

  localparam int unsigned TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] LANE_B0 = 2'b00;  // bits  7:0
  localparam logic [1:0] LANE_B1 = 2'b01;  // bits 15:8
  localparam logic [1:0] LANE_B2 = 2'b10;  // bits 23:16
  localparam logic [1:0] LANE_B3 = 2'b11;  // bits 31:24

  function automatic logic [31:0] sext8(input logic [7:0] b);
    return {{24{b[7]}}, b};
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/acknowledge data-memory bus.
//   dm_req   : access request            (master -> slave)
//   dm_we    : 1 = write                 (master -> slave)
//   dm_addr  : word-aligned address      (master -> slave)
//   dm_wdata : store data                (master -> slave)
//   dm_ack   : access complete           (slave -> master)
//   dm_rdata : read word, valid with ack (slave -> master)
interface mem_access_unit_if;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic        dm_ack;
  logic [31:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata,
    input  dm_ack, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata,
    output dm_ack, dm_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// load_extract: combinational load-data formatting.
//   i_rdata   : raw word from memory
//   i_addr_lo : byte offset (address bits [1:0])
//   i_lb      : 1 = lb (selected byte, sign-extended), 0 = lw (word as-is)
//   o_data    : formatted load data
module load_extract
  import mem_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic        i_lb,
  output logic [31:0] o_data
);

  logic [7:0] w_byte;

  always_comb begin
    w_byte = '0;
    case (i_addr_lo)
      LANE_B0: w_byte = i_rdata[7:0];
      LANE_B1: w_byte = i_rdata[15:8];
      LANE_B2: w_byte = i_rdata[23:16];
      LANE_B3: w_byte = i_rdata[31:24];
      default: w_byte = '0;
    endcase
    o_data = i_lb ? sext8(w_byte) : i_rdata;
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage data-memory access unit.
//   clk, reset       : pipeline clock, synchronous active-high reset
//   MEM_*            : EX/MEM register outputs (control, Rw, ALUOut, Op2, PCplus8)
//   dm               : data-memory bus (master side)
//   stall            : freeze PC, IF/ID, ID/EX, EX/MEM while an access is outstanding
//   WB_*             : registered MEM/WB values
//   bus_err          : sticky flag, set when an access times out
//   stall_cnt        : total stall cycles (wraps)
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               MEM_MemRead,
  input  logic               MEM_MemWrite,
  input  logic               MEM_RegWrite,
  input  logic               MEM_LbOp,
  input  logic [1:0]         MEM_MemtoReg,
  input  logic [4:0]         MEM_Rw,
  input  logic [31:0]        MEM_ALUOut,
  input  logic [31:0]        MEM_Op2,
  input  logic [31:0]        MEM_PCplus8,
  mem_access_unit_if.master  dm,
  output logic               stall,
  output logic               WB_RegWrite,
  output logic [1:0]         WB_MemtoReg,
  output logic [4:0]         WB_Rw,
  output logic [31:0]        WB_ALUOut,
  output logic [31:0]        WB_MemData,
  output logic [31:0]        WB_PCplus8,
  output logic               bus_err,
  output logic [31:0]        stall_cnt
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_t          r_state;
  logic [CW-1:0]   r_wait_cnt;

  logic            w_acc;
  logic            w_timeout;
  logic            w_complete;
  logic            w_req;
  logic [31:0]     w_load;
  logic [31:0]     w_memdata;

  assign w_acc = MEM_MemRead | MEM_MemWrite;

  // An ack arriving in the final wait cycle is a normal completion, not a timeout.
  assign w_timeout  = (r_state == WAIT) && (r_wait_cnt == CW'(TIMEOUT - 1)) && !dm.dm_ack;
  assign w_complete = dm.dm_ack | w_timeout;

  // Request is held for the whole WAIT state; address/data come straight from
  // the EX/MEM inputs, which upstream holds constant while stalled.
  assign w_req = (r_state == WAIT) | w_acc;

  always_comb begin
    dm.dm_req   = ~reset & w_req;
    dm.dm_we    = ~reset & w_req & MEM_MemWrite;
    dm.dm_addr  = {MEM_ALUOut[31:2], 2'b00};
    dm.dm_wdata = MEM_Op2;
    stall       = ~reset & w_acc & ~w_complete;
  end

  load_extract u_load_extract (
    .i_rdata   (dm.dm_rdata),
    .i_addr_lo (MEM_ALUOut[1:0]),
    .i_lb      (MEM_LbOp),
    .o_data    (w_load)
  );

  assign w_memdata = w_timeout ? '0 : w_load;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait_cnt  <= '0;
      WB_RegWrite <= 1'b0;
      WB_MemtoReg <= '0;
      WB_Rw       <= '0;
      WB_ALUOut   <= '0;
      WB_MemData  <= '0;
      WB_PCplus8  <= '0;
      bus_err     <= 1'b0;
      stall_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_wait_cnt <= '0;
          if (w_acc && !dm.dm_ack) r_state <= WAIT;
        end
        WAIT: begin
          if (w_complete) begin
            r_state    <= IDLE;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + CW'(1);
          end
        end
        default: begin
          r_state    <= IDLE;
          r_wait_cnt <= '0;
        end
      endcase

      if (w_timeout) bus_err <= 1'b1;

      if (stall) begin
        stall_cnt   <= stall_cnt + 32'd1;
        WB_RegWrite <= 1'b0;
      end else begin
        WB_RegWrite <= MEM_RegWrite;
        WB_MemtoReg <= MEM_MemtoReg;
        WB_Rw       <= MEM_Rw;
        WB_ALUOut   <= MEM_ALUOut;
        WB_MemData  <= w_memdata;
        WB_PCplus8  <= MEM_PCplus8;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed self-checking bench for mem_access_unit.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk;
  logic        reset;
  logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite, MEM_LbOp;
  logic [1:0]  MEM_MemtoReg;
  logic [4:0]  MEM_Rw;
  logic [31:0] MEM_ALUOut, MEM_Op2, MEM_PCplus8;
  logic        stall;
  logic        WB_RegWrite;
  logic [1:0]  WB_MemtoReg;
  logic [4:0]  WB_Rw;
  logic [31:0] WB_ALUOut, WB_MemData, WB_PCplus8;
  logic        bus_err;
  logic [31:0] stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  mem_access_unit_if u_if ();

  mem_access_unit #(.TIMEOUT(16)) u_dut (
    .clk          (clk),
    .reset        (reset),
    .MEM_MemRead  (MEM_MemRead),
    .MEM_MemWrite (MEM_MemWrite),
    .MEM_RegWrite (MEM_RegWrite),
    .MEM_LbOp     (MEM_LbOp),
    .MEM_MemtoReg (MEM_MemtoReg),
    .MEM_Rw       (MEM_Rw),
    .MEM_ALUOut   (MEM_ALUOut),
    .MEM_Op2      (MEM_Op2),
    .MEM_PCplus8  (MEM_PCplus8),
    .dm           (u_if),
    .stall        (stall),
    .WB_RegWrite  (WB_RegWrite),
    .WB_MemtoReg  (WB_MemtoReg),
    .WB_Rw        (WB_Rw),
    .WB_ALUOut    (WB_ALUOut),
    .WB_MemData   (WB_MemData),
    .WB_PCplus8   (WB_PCplus8),
    .bus_err      (bus_err),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic set_op(input logic rd, input logic wr, input logic rw, input logic lb,
                        input logic [1:0] mtr, input logic [4:0] rdst,
                        input logic [31:0] alu, input logic [31:0] op2, input logic [31:0] pc8);
    MEM_MemRead  = rd;
    MEM_MemWrite = wr;
    MEM_RegWrite = rw;
    MEM_LbOp     = lb;
    MEM_MemtoReg = mtr;
    MEM_Rw       = rdst;
    MEM_ALUOut   = alu;
    MEM_Op2      = op2;
    MEM_PCplus8  = pc8;
  endtask

  task automatic bus(input logic ack, input logic [31:0] rdata);
    u_if.dm_ack   = ack;
    u_if.dm_rdata = rdata;
  endtask

  // lb byte-lane table on 0x80FF0011
  logic [31:0] lb_addr [4];
  logic [31:0] lb_exp  [4];

  initial begin
    lb_addr = '{32'h13, 32'h12, 32'h11, 32'h10};
    lb_exp  = '{32'hFFFFFF80, 32'hFFFFFFFF, 32'h00000000, 32'h00000011};

    // ---- reset ----
    reset = 1'b1;
    set_op(1'b1, 1'b1, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'h4, 32'h0, 32'h0);
    bus(1'b0, 32'h0);
    @(negedge clk); #1;
    check("rst_dm_req", 32'(u_if.dm_req), 32'h0);
    check("rst_dm_we", 32'(u_if.dm_we), 32'h0);
    check("rst_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("rst_wb_regwrite", 32'(WB_RegWrite), 32'h0);
    check("rst_wb_memdata", WB_MemData, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    check("rst_stall_cnt", stall_cnt, 32'h0);

    // ---- zero-wait lw at 0x10 ----
    @(negedge clk);
    reset = 1'b0;
    set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd5, 32'h10, 32'h0, 32'h100);
    bus(1'b1, 32'h12345678);
    #1;
    check("lw0_stall", 32'(stall), 32'h0);
    check("lw0_dm_req", 32'(u_if.dm_req), 32'h1);
    check("lw0_dm_we", 32'(u_if.dm_we), 32'h0);
    check("lw0_dm_addr", u_if.dm_addr, 32'h10);
    @(posedge clk); #1;
    check("lw0_wb_memdata", WB_MemData, 32'h12345678);
    check("lw0_wb_regwrite", 32'(WB_RegWrite), 32'h1);
    check("lw0_wb_rw", 32'(WB_Rw), 32'd5);
    check("lw0_wb_mtr", 32'(WB_MemtoReg), 32'(MTR_MEM));
    check("lw0_wb_pc8", WB_PCplus8, 32'h100);
    check("lw0_stall_cnt", stall_cnt, 32'h0);

    // ---- lw ignores low address bits ----
    @(negedge clk);
    set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd6, 32'h13, 32'h0, 32'h104);
    bus(1'b1, 32'h80FF0011);
    #1;
    check("lw13_dm_addr", u_if.dm_addr, 32'h10);
    @(posedge clk); #1;
    check("lw13_wb_memdata", WB_MemData, 32'h80FF0011);

    // ---- lb byte lanes ----
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      set_op(1'b1, 1'b0, 1'b1, 1'b1, MTR_MEM, 5'd8, lb_addr[i], 32'h0, 32'h108);
      bus(1'b1, 32'h80FF0011);
      #1;
      check($sformatf("lb%0h_stall", lb_addr[i]), 32'(stall), 32'h0);
      @(posedge clk); #1;
      check($sformatf("lb%0h_wb_memdata", lb_addr[i]), WB_MemData, lb_exp[i]);
    end

    // ---- sw, ack in 3rd cycle after the request cycle ----
    for (int k = 0; k <= 3; k++) begin
      @(negedge clk);
      set_op(1'b0, 1'b1, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'h24, 32'hCAFEF00D, 32'h10C);
      bus(k == 3, 32'h0);
      #1;
      check($sformatf("sw_c%0d_stall", k), 32'(stall), (k < 3) ? 32'h1 : 32'h0);
      check($sformatf("sw_c%0d_req", k), 32'(u_if.dm_req), 32'h1);
      check($sformatf("sw_c%0d_we", k), 32'(u_if.dm_we), 32'h1);
      check($sformatf("sw_c%0d_addr", k), u_if.dm_addr, 32'h24);
      check($sformatf("sw_c%0d_wdata", k), u_if.dm_wdata, 32'hCAFEF00D);
      @(posedge clk); #1;
      check($sformatf("sw_c%0d_wb_regwrite", k), 32'(WB_RegWrite), 32'h0);
      check($sformatf("sw_c%0d_wb_aluout", k), WB_ALUOut, (k < 3) ? 32'h10 : 32'h24);
    end
    check("sw_stall_cnt", stall_cnt, 32'd3);

    // ---- lw timeout: ack never comes ----
    for (int k = 0; k <= 16; k++) begin
      @(negedge clk);
      set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd10, 32'h40, 32'h0, 32'h110);
      bus(1'b0, 32'hDEADBEEF);
      #1;
      check($sformatf("to_c%0d_stall", k), 32'(stall), (k < 16) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
      check($sformatf("to_c%0d_bus_err", k), 32'(bus_err), (k == 16) ? 32'h1 : 32'h0);
      check($sformatf("to_c%0d_wb_regwrite", k), 32'(WB_RegWrite), (k == 16) ? 32'h1 : 32'h0);
    end
    check("to_wb_memdata", WB_MemData, 32'h0);
    check("to_stall_cnt", stall_cnt, 32'd19);

    // ---- successful lw after timeout: bus_err is sticky ----
    @(negedge clk);
    set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd11, 32'h44, 32'h0, 32'h114);
    bus(1'b1, 32'hA5A5A5A5);
    #1;
    check("post_to_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("post_to_wb_memdata", WB_MemData, 32'hA5A5A5A5);
    check("post_to_bus_err", 32'(bus_err), 32'h1);

    // ---- reset in the 2nd WAIT cycle ----
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd12, 32'h50, 32'h0, 32'h118);
      bus(1'b0, 32'h0);
      #1;
      check($sformatf("rw_c%0d_stall", k), 32'(stall), 32'h1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rw_dm_req", 32'(u_if.dm_req), 32'h0);
    check("rw_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("rw_wb_regwrite", 32'(WB_RegWrite), 32'h0);
    check("rw_wb_memdata", WB_MemData, 32'h0);
    check("rw_wb_aluout", WB_ALUOut, 32'h0);
    check("rw_wb_rw", 32'(WB_Rw), 32'h0);
    check("rw_wb_pc8", WB_PCplus8, 32'h0);
    check("rw_wb_mtr", 32'(WB_MemtoReg), 32'h0);
    check("rw_bus_err", 32'(bus_err), 32'h0);
    check("rw_stall_cnt", stall_cnt, 32'h0);

    // late ack with no access pending
    @(negedge clk);
    reset = 1'b0;
    set_op(1'b0, 1'b0, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'h0, 32'h0, 32'h0);
    bus(1'b1, 32'h77777777);
    #1;
    check("late_ack_dm_req", 32'(u_if.dm_req), 32'h0);
    check("late_ack_stall", 32'(stall), 32'h0);
    @(posedge clk); #1;
    check("late_ack_wb_regwrite", 32'(WB_RegWrite), 32'h0);
    check("late_ack_stall_cnt", stall_cnt, 32'h0);

    // ---- back-to-back lw / sw / ALU op, 1-cycle ack each ----
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_op(1'b1, 1'b0, 1'b1, 1'b0, MTR_MEM, 5'd7, 32'h60, 32'h0, 32'h200);
      bus(k == 1, 32'h11112222);
      #1;
      check($sformatf("b2b_lw_c%0d_stall", k), 32'(stall), (k == 0) ? 32'h1 : 32'h0);
      @(posedge clk); #1;
    end
    check("b2b_lw_wb_memdata", WB_MemData, 32'h11112222);
    check("b2b_lw_wb_regwrite", 32'(WB_RegWrite), 32'h1);
    check("b2b_lw_wb_rw", 32'(WB_Rw), 32'd7);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      set_op(1'b0, 1'b1, 1'b0, 1'b0, MTR_ALU, 5'd0, 32'h64, 32'h33334444, 32'h204);
      bus(k == 1, 32'h0);
      #1;
      check($sformatf("b2b_sw_c%0d_stall", k), 32'(stall), (k == 0) ? 32'h1 : 32'h0);
      check($sformatf("b2b_sw_c%0d_wdata", k), u_if.dm_wdata, 32'h33334444);
      @(posedge clk); #1;
    end
    @(negedge clk);
    set_op(1'b0, 1'b0, 1'b1, 1'b0, MTR_ALU, 5'd9, 32'h0BADCAFE, 32'h0, 32'h208);
    bus(1'b0, 32'h0);
    #1;
    check("b2b_alu_stall", 32'(stall), 32'h0);
    check("b2b_alu_dm_req", 32'(u_if.dm_req), 32'h0);
    @(posedge clk); #1;
    check("b2b_alu_wb_aluout", WB_ALUOut, 32'h0BADCAFE);
    check("b2b_alu_wb_rw", 32'(WB_Rw), 32'd9);
    check("b2b_alu_wb_regwrite", 32'(WB_RegWrite), 32'h1);
    check("b2b_alu_wb_pc8", WB_PCplus8, 32'h208);
    check("b2b_stall_cnt", stall_cnt, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
